// File: rtl/writeback_unit.sv
// Register-file writeback arbiter: single-cycle ALU results take priority over an
// in-order FIFO of long-latency results; also tracks per-register outstanding writes.
module writeback_unit #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               alu_valid,
  input  logic [4:0]                         alu_rd,
  input  logic [31:0]                        alu_data,
  input  logic                               mem_valid,
  output logic                               mem_ready,
  input  logic [4:0]                         mem_rd,
  input  logic [31:0]                        mem_data,
  input  logic                               issue_valid,
  input  logic [4:0]                         issue_rd,
  output logic [4:0]                         write_register,
  output logic [31:0]                        write_data,
  output logic                               write_enable,
  output logic [31:0]                        pending,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  wb_entry_t        fifo_q [FIFO_DEPTH];
  wb_entry_t        fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             we_q, we_d;
  logic [4:0]       wreg_q, wreg_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      pending_q, pending_d;

  logic             enq;
  logic             alu_grant;
  logic             fifo_grant;
  wb_entry_t        head;

  assign mem_ready  = (count_q != CNT_W'(FIFO_DEPTH));
  assign enq        = mem_valid && mem_ready;
  assign alu_grant  = alu_valid && (alu_rd != 5'd0);
  assign fifo_grant = !alu_grant && (count_q != CNT_W'(0));
  assign head       = fifo_q[rd_ptr_q];

  // Arbitration, FIFO bookkeeping and scoreboard update.
  always_comb begin
    fifo_d    = fifo_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    we_d      = 1'b0;
    wreg_d    = wreg_q;
    wdata_d   = wdata_q;
    pending_d = pending_q;

    if (alu_grant) begin
      we_d    = 1'b1;
      wreg_d  = alu_rd;
      wdata_d = alu_data;
    end else if (fifo_grant && (head.rd != 5'd0)) begin
      we_d    = 1'b1;
      wreg_d  = head.rd;
      wdata_d = head.data;
    end

    if (fifo_grant) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (enq) begin
      fifo_d[wr_ptr_q] = '{rd: mem_rd, data: mem_data};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(enq) - CNT_W'(fifo_grant);

    // A new issue to the same register outranks the completing write.
    if (we_d) begin
      pending_d[wreg_d] = 1'b0;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      pending_d[issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      we_q      <= 1'b0;
      wreg_q    <= '0;
      wdata_q   <= '0;
      pending_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      we_q      <= we_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
      pending_q <= pending_d;
    end
  end

  // Entry storage needs no reset; occupancy is governed by the pointers.
  always_ff @(posedge clock) begin
    fifo_q <= fifo_d;
  end

  assign write_enable   = we_q;
  assign write_register = wreg_q;
  assign write_data     = wdata_q;
  assign pending        = pending_q;
  assign fifo_count     = count_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_writeback_unit;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset;
  logic             alu_valid;
  logic [4:0]       alu_rd;
  logic [31:0]      alu_data;
  logic             mem_valid;
  logic             mem_ready;
  logic [4:0]       mem_rd;
  logic [31:0]      mem_data;
  logic             issue_valid;
  logic [4:0]       issue_rd;
  logic [4:0]       write_register;
  logic [31:0]      write_data;
  logic             write_enable;
  logic [31:0]      pending;
  logic [CNT_W-1:0] fifo_count;

  int errors = 0;
  int checks = 0;

  writeback_unit #(.FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .write_register(write_register), .write_data(write_data), .write_enable(write_enable),
    .pending(pending), .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdata;
    logic        ewe;
    logic [4:0]  ereg;
    logic [31:0] edata;
    int          ecnt;
    logic        erdy;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  // Reference model state
  ent_t        mq[$];
  logic        m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  logic [31:0] m_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic rst, input logic av, input logic [4:0] ard,
                        input logic [31:0] adata, input logic mv, input logic [4:0] mrd,
                        input logic [31:0] mdata, input logic iv, input logic [4:0] ird);
    reset = rst; alu_valid = av; alu_rd = ard; alu_data = adata;
    mem_valid = mv; mem_rd = mrd; mem_data = mdata; issue_valid = iv; issue_rd = ird;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic we, input logic [4:0] r,
                          input logic [31:0] d);
    check({tag, ".we"}, 32'(write_enable), 32'(we));
    check({tag, ".reg"}, 32'(write_register), 32'(r));
    check({tag, ".data"}, write_data, d);
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    bit   accept;
    ent_t e;
    if (reset) begin
      mq.delete();
      m_we = 1'b0; m_reg = '0; m_data = '0; m_pend = '0;
    end else begin
      accept = mem_valid && (mq.size() < DEPTH);
      m_we = 1'b0;
      if (alu_valid && alu_rd != 5'd0) begin
        m_we = 1'b1; m_reg = alu_rd; m_data = alu_data;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        if (e.rd != 5'd0) begin
          m_we = 1'b1; m_reg = e.rd; m_data = e.data;
        end
      end
      if (accept) mq.push_back('{rd: mem_rd, data: mem_data});
      if (m_we) m_pend[m_reg] = 1'b0;
      if (issue_valid && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
    end
  endtask

  vec_t vecs[14];

  initial begin
    // rst av ard adata mv mrd mdata | we reg data cnt rdy
    vecs[0]  = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,        0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 32'hDEADBEEF, 0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd5, 32'hDEADBEEF, 0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h77,   1'b0, 5'd5, 32'hDEADBEEF, 1, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 5'd3, 32'h33,       1'b0, 5'd0, 32'h0,    1'b1, 5'd3, 32'h33,       1, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'h77,       0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd7, 32'h77,       0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h99,   1'b0, 5'd7, 32'h77,       1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 5'd0, 32'hBAD,      1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 32'h99,       0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h1234, 1'b0, 5'd9, 32'h99,       1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd9, 32'h99,       0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd2, 32'h22,   1'b0, 5'd9, 32'h99,       1, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 32'h44,   1'b1, 5'd2, 32'h22,       1, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd4, 32'h44,       0, 1'b1};

    set_in(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      set_in(vecs[i].rst, vecs[i].av, vecs[i].ard, vecs[i].adata,
             vecs[i].mv, vecs[i].mrd, vecs[i].mdata, 1'b0, 5'd0);
      tick();
      check_wr($sformatf("vec%0d", i), vecs[i].ewe, vecs[i].ereg, vecs[i].edata);
      check($sformatf("vec%0d.cnt", i), 32'(fifo_count), 32'(vecs[i].ecnt));
      check($sformatf("vec%0d.rdy", i), 32'(mem_ready), 32'(vecs[i].erdy));
    end
    check("vec.pending", pending, 32'h0);

    // Backpressure: ALU holds the port while 4 mem results fill the FIFO
    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, 1'b1, 5'd1, 32'hA0 + 32'(k), 1'b1, 5'(10 + k), 32'h100 + 32'(k), 1'b0, 5'd0);
      check($sformatf("bp.rdy_before%0d", k), 32'(mem_ready), 32'h1);
      tick();
      check($sformatf("bp.cnt%0d", k), 32'(fifo_count), 32'(k + 1));
      check_wr($sformatf("bp.alu%0d", k), 1'b1, 5'd1, 32'hA0 + 32'(k));
    end
    check("bp.full_rdy", 32'(mem_ready), 32'h0);
    for (int k = 0; k < 2; k++) begin
      set_in(1'b0, 1'b1, 5'd1, 32'hB0, 1'b1, 5'd14, 32'h104, 1'b0, 5'd0);
      tick();
      check("bp.hold_cnt", 32'(fifo_count), 32'd4);
      check("bp.hold_rdy", 32'(mem_ready), 32'h0);
    end
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'h104, 1'b0, 5'd0);
    tick();
    check_wr("bp.drain0", 1'b1, 5'd10, 32'h100);
    check("bp.drain0_cnt", 32'(fifo_count), 32'd3);
    check("bp.drain0_rdy", 32'(mem_ready), 32'h1);
    tick();
    check_wr("bp.drain1", 1'b1, 5'd11, 32'h101);
    check("bp.drain1_cnt", 32'(fifo_count), 32'd3);
    mem_valid = 1'b0;
    for (int k = 2; k < 5; k++) begin
      tick();
      check_wr($sformatf("bp.drain%0d", k), 1'b1, 5'(10 + k), 32'h100 + 32'(k));
      check($sformatf("bp.drain%0d_cnt", k), 32'(fifo_count), 32'(4 - k));
    end
    tick();
    check("bp.idle_we", 32'(write_enable), 32'h0);

    // Scoreboard set, set-wins-over-clear, and plain clear
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12);
    tick();
    check("sb.set12", pending, 32'h0000_1000);
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC12, 1'b0, 5'd0);
    tick();
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12);
    tick();
    check_wr("sb.wr12", 1'b1, 5'd12, 32'hC12);
    check("sb.setwins", pending, 32'h0000_1000);
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd20);
    tick();
    check("sb.set20", pending, 32'h0010_1000);
    set_in(1'b0, 1'b1, 5'd20, 32'h2020, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
    tick();
    check("sb.clr20", pending, 32'h0000_1000);

    // Mid-operation reset with 3 buffered results and pending = 0xF000
    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, 1'b1, 5'd1, 32'h1, k < 3, 5'd12 + 5'(k), 32'hE0 + 32'(k), 1'b1, 5'd12 + 5'(k));
      tick();
    end
    check("rst.pre_cnt", 32'(fifo_count), 32'd3);
    check("rst.pre_pend", pending, 32'h0000_F000);
    set_in(1'b1, 1'b1, 5'd6, 32'h66, 1'b1, 5'd8, 32'h88, 1'b1, 5'd9);
    tick();
    check("rst.cnt", 32'(fifo_count), 32'd0);
    check("rst.pend", pending, 32'h0);
    check("rst.rdy", 32'(mem_ready), 32'h1);
    check_wr("rst", 1'b0, 5'd0, 32'h0);
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    tick();
    check("rst.after_we", 32'(write_enable), 32'h0);
    check("rst.after_cnt", 32'(fifo_count), 32'd0);

    // Randomized traffic against the reference model
    set_in(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    model_step();
    tick();
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 199) == 0);
      alu_valid   = ($urandom_range(0, 9) < 4);
      alu_rd      = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      alu_data    = $urandom;
      mem_valid   = ($urandom_range(0, 9) < 5);
      mem_rd      = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mem_data    = $urandom;
      issue_valid = ($urandom_range(0, 9) < 3);
      issue_rd    = 5'($urandom_range(0, 31));
      check("rnd.rdy_pre", 32'(mem_ready), 32'(mq.size() != DEPTH));
      model_step();
      tick();
      check("rnd.we", 32'(write_enable), 32'(m_we));
      check("rnd.reg", 32'(write_register), 32'(m_reg));
      check("rnd.data", write_data, m_data);
      check("rnd.pend", pending, m_pend);
      check("rnd.cnt", 32'(fifo_count), 32'(mq.size()));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
